// File: rtl/led_chaser_pkg.sv
// Shared encodings for the LED chaser.
//   MODE_*  : values of the 2-bit mode input
//   state_t : run/idle state of the chaser FSM
package led_chaser_pkg;

  localparam logic [1:0] MODE_ROT  = 2'b00;
  localparam logic [1:0] MODE_BNC  = 2'b01;
  localparam logic [1:0] MODE_FILL = 2'b10;
  localparam logic [1:0] MODE_FRZ  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for the start/stop button.
//   clk_div : clock
//   rst     : asynchronous active-high reset (clears the history bit)
//   in      : level input, synchronous to clk_div
//   pulse   : high for the cycle in which in=1 and the previous sample was 0
module btn_edge (
  input  logic clk_div,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= in;
    end
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/led_chaser.sv
// LED chaser: a button-toggled run/idle FSM that steps an LED pattern
// (rotate, bounce, fill/drain or freeze) once every speed+1 cycles.
//   clk_div : clock
//   rst     : asynchronous active-high reset
//   button  : start/stop request (level; rising edge toggles run/idle)
//   dir_set : 1 = toward MSB, 0 = toward LSB
//   mode    : 00 rotate, 01 bounce, 10 fill, 11 freeze
//   speed   : step period minus one, in clk_div cycles
//   led     : current pattern (registered)
//   running : 1 while in RUN (registered)
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SPD_W = 4
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic             button,
  input  logic             dir_set,
  input  logic [1:0]       mode,
  input  logic [SPD_W-1:0] speed,
  output logic [WIDTH-1:0] led,
  output logic             running
);

  localparam logic [WIDTH-1:0] LED_INIT = WIDTH'(1);

  state_t           state;
  logic [SPD_W-1:0] cnt;
  logic             bdir;
  logic             grow;
  logic [1:0]       mode_q;
  logic             btn_pulse;
  logic             step;

  btn_edge u_btn_edge (
    .clk_div (clk_div),
    .rst     (rst),
    .in      (button),
    .pulse   (btn_pulse)
  );

  assign step = (state == ST_RUN) && (cnt == speed);

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      led     <= LED_INIT;
      cnt     <= '0;
      bdir    <= 1'b1;
      grow    <= 1'b1;
      // Track the live mode so leaving reset is not seen as a mode change.
      mode_q  <= mode;
    end else if (btn_pulse) begin
      // Toggle only; a mode change seen now is reloaded on the next cycle.
      cnt <= '0;
      if (state == ST_IDLE) begin
        state   <= ST_RUN;
        running <= 1'b1;
        bdir    <= dir_set;
      end else begin
        state   <= ST_IDLE;
        running <= 1'b0;
      end
    end else if (mode != mode_q) begin
      mode_q <= mode;
      led    <= LED_INIT;
      cnt    <= '0;
      grow   <= 1'b1;
    end else if (state == ST_RUN) begin
      if (step) begin
        cnt <= '0;
        unique case (mode)
          MODE_ROT: begin
            led <= dir_set ? {led[WIDTH-2:0], led[WIDTH-1]} : {led[0], led[WIDTH-1:1]};
          end
          MODE_BNC: begin
            // Turn around at the end in the same step so the end value never repeats.
            if (bdir) begin
              if (led[WIDTH-1]) begin
                bdir <= 1'b0;
                led  <= {1'b0, led[WIDTH-1:1]};
              end else begin
                led  <= {led[WIDTH-2:0], 1'b0};
              end
            end else begin
              if (led[0]) begin
                bdir <= 1'b1;
                led  <= {led[WIDTH-2:0], 1'b0};
              end else begin
                led  <= {1'b0, led[WIDTH-1:1]};
              end
            end
          end
          MODE_FILL: begin
            if (grow) begin
              if (&led) begin
                grow <= 1'b0;
                led  <= {1'b0, led[WIDTH-1:1]};
              end else begin
                led  <= {led[WIDTH-2:0], 1'b1};
              end
            end else begin
              if (~|led) begin
                grow <= 1'b1;
                led  <= {led[WIDTH-2:0], 1'b1};
              end else begin
                led  <= {1'b0, led[WIDTH-1:1]};
              end
            end
          end
          MODE_FRZ: begin
            led <= led;
          end
        endcase
      end else begin
        // Wraps naturally if speed was lowered below the current count.
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
module tb_led_chaser;

  logic       clk_div = 1'b0;
  logic       rst     = 1'b0;
  logic       button  = 1'b0;
  logic       dir_set = 1'b1;
  logic [1:0] mode    = 2'b00;
  logic [3:0] speed   = 4'd0;
  logic [7:0] led;
  logic       running;

  int pass_cnt  = 0;
  int total_cnt = 0;

  led_chaser #(
    .WIDTH (8),
    .SPD_W (4)
  ) dut (
    .clk_div (clk_div),
    .rst     (rst),
    .button  (button),
    .dir_set (dir_set),
    .mode    (mode),
    .speed   (speed),
    .led     (led),
    .running (running)
  );

  always #5 clk_div = ~clk_div;

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // One-cycle button press starting from button=0.
  task automatic press();
    button = 1'b1;
    tick();
    button = 1'b0;
  endtask

  task automatic test_reset();
    mode   = 2'b00;
    button = 1'b0;
    rst    = 1'b1;
    #1;
    total_cnt++;
    if (led !== 8'h01) $display("FAIL reset_led: got %h want 01", led);
    else pass_cnt++;
    total_cnt++;
    if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (led !== 8'h01 || running !== 1'b0)
      $display("FAIL idle_after_reset: got led=%h run=%b want 01/0", led, running);
    else pass_cnt++;
  endtask

  task automatic test_rotate();
    logic [7:0] exp_rot [8] = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    mode = 2'b00; dir_set = 1'b1; speed = 4'd0;
    do_reset();
    tick();
    press();
    total_cnt++;
    if (led !== 8'h01 || running !== 1'b1)
      $display("FAIL rot_edge_cycle: got led=%h run=%b want 01/1", led, running);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (led !== 8'h02) $display("FAIL rot_first_step: got %h want 02", led);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      tick();
      total_cnt++;
      if (led !== exp_rot[i]) $display("FAIL rot_step%0d: got %h want %h", i, led, exp_rot[i]);
      else pass_cnt++;
    end
    // Reverse direction: 02 -> 01 -> 80
    dir_set = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (led !== 8'h80) $display("FAIL rot_right_wrap: got %h want 80", led);
    else pass_cnt++;
    // Stop edge coincides with a due step: toggle only, no shift.
    press();
    total_cnt++;
    if (led !== 8'h80 || running !== 1'b0)
      $display("FAIL edge_no_step: got led=%h run=%b want 80/0", led, running);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (led !== 8'h80) $display("FAIL idle_hold: got %h want 80", led);
    else pass_cnt++;
  endtask

  task automatic test_hold_speed();
    int rise_errs = 0;
    mode = 2'b00; dir_set = 1'b1; speed = 4'd3;
    do_reset();
    tick();
    button = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (running !== 1'b1) rise_errs++;
      if (k == 4) begin
        total_cnt++;
        if (led !== 8'h01) $display("FAIL spd_before_step: got %h want 01", led);
        else pass_cnt++;
      end
      if (k == 5) begin
        total_cnt++;
        if (led !== 8'h02) $display("FAIL spd_first_step: got %h want 02", led);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (rise_errs != 0) $display("FAIL held_button_single_toggle: got %0d bad cycles want 0", rise_errs);
    else pass_cnt++;
    total_cnt++;
    if (led !== 8'h10) $display("FAIL spd_after_20: got %h want 10", led);
    else pass_cnt++;
    button = 1'b0;
    tick();
    total_cnt++;
    if (led !== 8'h20) $display("FAIL spd_step21: got %h want 20", led);
    else pass_cnt++;
    press();
    tick(); tick(); tick(); tick(); tick();
    total_cnt++;
    if (led !== 8'h20 || running !== 1'b0)
      $display("FAIL spd_stop_frozen: got led=%h run=%b want 20/0", led, running);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    logic [7:0] exp_bnc [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    mode = 2'b01; dir_set = 1'b1; speed = 4'd0;
    do_reset();
    tick();
    press();
    for (int i = 0; i < 16; i++) begin
      tick();
      total_cnt++;
      if (led !== exp_bnc[i]) $display("FAIL bnc_step%0d: got %h want %h", i, led, exp_bnc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_fill [17] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F, 8'h3F,
                                  8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h01, 8'h03};
    mode = 2'b10; dir_set = 1'b0; speed = 4'd0;
    do_reset();
    tick();
    press();
    for (int i = 0; i < 17; i++) begin
      tick();
      total_cnt++;
      if (led !== exp_fill[i]) $display("FAIL fill_step%0d: got %h want %h", i, led, exp_fill[i]);
      else pass_cnt++;
    end
    // Mode switch while a step is due every cycle: reload wins.
    mode = 2'b00; dir_set = 1'b1;
    tick();
    total_cnt++;
    if (led !== 8'h01) $display("FAIL mode_reload: got %h want 01", led);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (led !== 8'h02) $display("FAIL after_reload_step: got %h want 02", led);
    else pass_cnt++;
    // Reload must clear cnt: with speed=2 the next step is 3 cycles later.
    speed = 4'd2; mode = 2'b01;
    tick();
    total_cnt++;
    if (led !== 8'h01) $display("FAIL reload_bnc: got %h want 01", led);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (led !== 8'h01) $display("FAIL reload_cnt_clear: got %h want 01", led);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (led !== 8'h02) $display("FAIL reload_cnt_step: got %h want 02", led);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    mode = 2'b11; speed = 4'd0;
    tick();
    tick();
    tick();
    total_cnt++;
    if (led !== 8'h01 || running !== 1'b1)
      $display("FAIL freeze_hold: got led=%h run=%b want 01/1", led, running);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    mode = 2'b00; dir_set = 1'b1; speed = 4'd0;
    do_reset();
    tick();
    press();
    tick(); tick(); tick();
    total_cnt++;
    if (led !== 8'h08) $display("FAIL pre_async: got %h want 08", led);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (led !== 8'h01 || running !== 1'b0)
      $display("FAIL async_reset: got led=%h run=%b want 01/0", led, running);
    else pass_cnt++;
    rst = 1'b0;
    tick(); tick(); tick();
    total_cnt++;
    if (led !== 8'h01 || running !== 1'b0)
      $display("FAIL need_restart: got led=%h run=%b want 01/0", led, running);
    else pass_cnt++;
    press();
    tick();
    total_cnt++;
    if (led !== 8'h02 || running !== 1'b1)
      $display("FAIL restart: got led=%h run=%b want 02/1", led, running);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_hold_speed();
    test_bounce();
    test_fill();
    test_freeze();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter: WIDTH, default 8, number of LEDs driven (legal range 2..32).
REQ-002 Parameter: SPD_W, default 4, width of the speed input.
REQ-003 clk_div  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 button  input  1  start/stop request, level, synchronous to clk_div.
REQ-006 dir_set  input  1  1 = shift toward MSB (left), 0 = toward LSB (right).
REQ-007 mode  input  2  00 rotate, 01 bounce, 10 fill, 11 freeze.
REQ-008 speed  input  SPD_W  one step every speed+1 clk_div cycles.
REQ-009 led  output  WIDTH  current pattern, driven directly from a register.
REQ-010 running  output  1  1 when the FSM is in RUN.

Function
REQ-011 FSM states: IDLE, RUN; a rising edge on button (button=1, previous-cycle button=0) toggles IDLE<->RUN; a held button causes exactly one toggle.
REQ-012 Prescaler: counter cnt (SPD_W bits) cleared in IDLE; in RUN it increments each cycle; step=1 when cnt==speed, and cnt clears on that cycle; speed=0 gives a step every cycle.
REQ-013 The led register changes only on a step cycle in RUN, except for mode-change reload (REQ-019) and reset.
REQ-014 Rotate (00): on step, led rotates one position in the dir_set direction, MSB<->LSB wrap.
REQ-015 Bounce (01): internal flag bdir, loaded from dir_set on every IDLE->RUN transition; on step, a single lit bit moves one position per bdir; when the lit bit is at the end toward which bdir points, bdir inverts and the bit moves one position the other way in that same step (no dwell at the ends).
REQ-016 Fill (10): on step in the grow phase, led <= {led[WIDTH-2:0],1'b1}; once led is all ones, the next step enters the shrink phase, led <= {1'b0,led[WIDTH-1:1]}; once led is all zeros, the next step re-enters grow; dir_set is ignored.
REQ-017 Freeze (11): led holds; the prescaler keeps running.
REQ-018 In IDLE, led holds its value; on RUN re-entry, motion resumes from the held pattern with cnt=0.
REQ-019 A change of mode (registered compare) in any state reloads led to WIDTH'b1, clears cnt, and sets fill phase = grow; the reload takes priority over a step in the same cycle.
REQ-020 Priority within one cycle: rst > button edge > mode reload > step; on a button-edge cycle no step occurs.
REQ-021 Changing dir_set mid-run takes effect on the next step (rotate) or the next IDLE->RUN transition (bounce).
REQ-022 If speed changes to a value below the current cnt, cnt continues to wrap at 2^SPD_W; no step is lost permanently and no glitch is produced on led.

Reset
REQ-023 During rst: led=WIDTH'b1 (LSB lit), running=0, state=IDLE, cnt=0, bdir=1, fill phase=grow, edge register=0, and the registered mode copy=current mode.
REQ-024 A reset asserted mid-run takes effect immediately and asynchronously; the first button edge after release is required to restart motion.

Structure
REQ-025 The shared package led_chaser_pkg holds the mode encodings (MODE_ROT, MODE_BNC, MODE_FILL, MODE_FRZ) and the state encoding (ST_IDLE, ST_RUN).
REQ-026 Button edge detection lives in the sub-module btn_edge (clk_div, rst, in -> pulse); everything else is in led_chaser.

Verification
REQ-027 Reset, press button for 1 cycle, mode=00, dir_set=1, speed=0, WIDTH=8 -> led 00000010 one cycle after the edge cycle, and 00000001 again after 8 steps.
REQ-028 Hold button for 20 cycles with speed=3 -> running rises once; led advances every 4 cycles; release and press again -> running=0 and led frozen.
REQ-029 mode=01, dir_set=1, WIDTH=8 -> sequence 01,02,...,80,40,20,...,01,02; no repeated value at the ends.
REQ-030 mode=10 -> 00,01,03,...,FF,7F,...,00,01 (starting from the reload value 01 after a mode change: 03,07,...); mode switch mid-run -> led=01 and cnt=0 on the next cycle, even when a step coincides.
REQ-031 Assert rst asynchronously mid-step with speed=0 -> led=01 and running=0 without waiting for a clock edge; a button edge and a step in the same cycle -> toggle only, no shift.
